// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter: round-robin sequencer sharing one fixed-latency multiplier among NUM_REQ requesters
module mult_share_arbiter #(
   parameter int WIDTH   = 8,
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = 2,
   parameter int TIMEOUT = 64
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_REQ-1:0]         req,
   input  logic [NUM_REQ*WIDTH-1:0]   req_multiplier,
   input  logic [NUM_REQ*WIDTH-1:0]   req_multiplicand,
   output logic [NUM_REQ-1:0]         grant,
   output logic [NUM_REQ-1:0]         rsp_valid,
   output logic [2*WIDTH-1:0]         rsp_product,
   output logic                       rsp_error,
   output logic [15:0]                rsp_cycles,
   output logic                       busy,
   output logic                       mult_start,
   output logic [WIDTH-1:0]           mult_multiplier,
   output logic [WIDTH-1:0]           mult_multiplicand,
   input  logic [2*WIDTH-1:0]         mult_product,
   input  logic                       mult_done
);
   localparam logic [1:0] IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, RESP = 2'd3;
   localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);
   logic [1:0]         state_q, state_d;
   logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d, owner_q, owner_d, win, idx;
   logic [WIDTH-1:0]   mplier_q, mplier_d, mcand_q, mcand_d;
   logic [15:0]        cnt_q, cnt_d, cnt_inc, cyc_q, cyc_d;
   logic [2*WIDTH-1:0] prod_q, prod_d;
   logic               err_q, err_d;
   // descending scan so the candidate closest above rr_ptr is the last one written
   always_comb begin
      win = rr_ptr_q;
      idx = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         idx = IDX_W'((int'(rr_ptr_q) + i) % NUM_REQ);
         win = req[idx] ? idx : win;
      end
   end
   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      owner_d  = owner_q;
      mplier_d = mplier_q;
      mcand_d  = mcand_q;
      cnt_inc  = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
      cnt_d    = cnt_q;
      prod_d   = prod_q;
      err_d    = err_q;
      cyc_d    = cyc_q;
      case (state_q)
         IDLE: if (|req) begin
            owner_d  = win;
            mplier_d = req_multiplier[win*WIDTH +: WIDTH];
            mcand_d  = req_multiplicand[win*WIDTH +: WIDTH];
            state_d  = ISSUE;
         end
         ISSUE: begin
            cnt_d   = '0;
            state_d = WAIT;
         end
         WAIT: begin
            cnt_d = cnt_inc;
            if (mult_done) begin
               prod_d  = mult_product;
               err_d   = 1'b0;
               cyc_d   = cnt_inc;
               state_d = RESP;
            end else if (cnt_inc >= 16'(TIMEOUT)) begin
               prod_d  = '0;
               err_d   = 1'b1;
               cyc_d   = 16'(TIMEOUT);
               state_d = RESP;
            end
         end
         default: begin
            rr_ptr_d = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
            state_d  = IDLE;
         end
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         rr_ptr_q <= '0;
         owner_q  <= '0;
         mplier_q <= '0;
         mcand_q  <= '0;
         cnt_q    <= '0;
         prod_q   <= '0;
         err_q    <= 1'b0;
         cyc_q    <= '0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         owner_q  <= owner_d;
         mplier_q <= mplier_d;
         mcand_q  <= mcand_d;
         cnt_q    <= cnt_d;
         prod_q   <= prod_d;
         err_q    <= err_d;
         cyc_q    <= cyc_d;
      end
   end
   assign grant             = (state_q == ISSUE) ? ONE << owner_q : '0;
   assign rsp_valid         = (state_q == RESP) ? ONE << owner_q : '0;
   assign mult_start        = state_q == ISSUE;
   assign busy              = state_q != IDLE;
   assign mult_multiplier   = mplier_q;
   assign mult_multiplicand = mcand_q;
   assign rsp_product       = prod_q;
   assign rsp_error         = err_q;
   assign rsp_cycles        = cyc_q;
endmodule

// File: tb/tb_mult_share_arbiter.sv
// tb_mult_share_arbiter: directed self-checking bench with a latency-programmable multiplier model
module tb_mult_share_arbiter;
   logic        clk = 1'b0, rst;
   logic [3:0]  req, grant, rsp_valid;
   logic [31:0] req_multiplier, req_multiplicand;
   logic [15:0] rsp_product, rsp_cycles, mult_product;
   logic        rsp_error, busy, mult_start, mult_done;
   logic [7:0]  mult_multiplier, mult_multiplicand;
   int          lat, wc, tests = 0, fails = 0, n;
   mult_share_arbiter dut (
      .clk(clk), .rst(rst), .req(req),
      .req_multiplier(req_multiplier), .req_multiplicand(req_multiplicand),
      .grant(grant), .rsp_valid(rsp_valid), .rsp_product(rsp_product),
      .rsp_error(rsp_error), .rsp_cycles(rsp_cycles), .busy(busy),
      .mult_start(mult_start), .mult_multiplier(mult_multiplier),
      .mult_multiplicand(mult_multiplicand), .mult_product(mult_product),
      .mult_done(mult_done)
   );
   always #5 clk = ~clk;
   // wc = index of the current WAIT cycle (1-based); lat = 0 means the multiplier never finishes
   always @(posedge clk)
      if (rst) wc <= 0;
      else if (mult_start) wc <= 1;
      else if (rsp_valid != 0) wc <= 0;
      else if (wc != 0) wc <= wc + 1;
   assign mult_done    = (lat != 0) && (wc == lat);
   assign mult_product = 16'(mult_multiplier) * 16'(mult_multiplicand);
   task automatic tick();
      @(negedge clk);
   endtask
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic wait_sig(input string tag, input bit on_rsp, output int cnt);
      cnt = 0;
      while (((on_rsp ? rsp_valid : grant) == 4'b0) && cnt < 100) begin
         tick();
         cnt++;
      end
      tests++;
      assert (cnt < 100) else begin
         fails++;
         $error("FAIL %s: waited %0d cycles, required fewer than 100", tag, cnt);
      end
   endtask
   task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b);
      req_multiplier[i*8 +: 8]   = a;
      req_multiplicand[i*8 +: 8] = b;
   endtask
   task automatic pulse_rst();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask
   initial begin
      logic [3:0]  eg;
      logic [15:0] ep [4];
      ep = '{16'hFE01, 16'h0001, 16'h0000, 16'h0100};
      rst = 1'b1; req = '0; req_multiplier = '0; req_multiplicand = '0; lat = 8;
      repeat (2) tick();
      chk("rst_grant", grant, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_start", mult_start, 0);
      chk("rst_product", rsp_product, 0);
      chk("rst_cycles", rsp_cycles, 0);
      chk("rst_error", rsp_error, 0);
      chk("rst_mplier", mult_multiplier, 0);
      chk("rst_mcand", mult_multiplicand, 0);
      // single op: 13*11, done on WAIT cycle 8
      rst = 1'b0; req = 4'b0001; set_op(0, 13, 11);
      tick();
      chk("t1_grant", grant, 4'b0001);
      chk("t1_start", mult_start, 1);
      chk("t1_mplier", mult_multiplier, 13);
      chk("t1_mcand", mult_multiplicand, 11);
      req = '0;
      repeat (8) begin
         tick();
         chk("t1_no_rsp_yet", rsp_valid, 0);
      end
      tick();
      chk("t1_rsp_valid", rsp_valid, 4'b0001);
      chk("t1_product", rsp_product, 16'h008F);
      chk("t1_error", rsp_error, 0);
      chk("t1_cycles", rsp_cycles, 8);
      tick();
      chk("t1_idle", busy, 0);
      chk("t1_held", rsp_product, 16'h008F);
      // full contention
      pulse_rst();
      lat = 3; req = 4'b1111;
      set_op(0, 255, 255); set_op(1, 1, 1); set_op(2, 0, 200); set_op(3, 128, 2);
      for (int k = 0; k < 4; k++) begin
         wait_sig("t2_wait_grant", 1'b0, n);
         chk("t2_grant", grant, 4'b0001 << k);
         req[k] = 1'b0;
         wait_sig("t2_wait_rsp", 1'b1, n);
         chk("t2_rsp_valid", rsp_valid, 4'b0001 << k);
         chk("t2_product", rsp_product, ep[k]);
      end
      // fairness: requester 0 re-requests at once, requester 2 held
      req = 4'b0101; set_op(0, 2, 3); set_op(2, 4, 5);
      for (int k = 0; k < 4; k++) begin
         eg = (k % 2 == 0) ? 4'b0001 : 4'b0100;
         wait_sig("t3_wait_grant", 1'b0, n);
         chk("t3_grant", grant, eg);
         if (eg[0]) req[0] = 1'b0;
         wait_sig("t3_wait_rsp", 1'b1, n);
         chk("t3_product", rsp_product, eg[0] ? 16'd6 : 16'd20);
         req[0] = 1'b1;
      end
      req = '0;
      // timeout: multiplier never finishes
      lat = 0; req = 4'b1000; set_op(3, 9, 9);
      wait_sig("t4_wait_grant", 1'b0, n);
      chk("t4_grant", grant, 4'b1000);
      req = '0;
      wait_sig("t4_wait_rsp", 1'b1, n);
      chk("t4_latency", n, 65);
      chk("t4_rsp_valid", rsp_valid, 4'b1000);
      chk("t4_error", rsp_error, 1);
      chk("t4_product", rsp_product, 0);
      chk("t4_cycles", rsp_cycles, 64);
      tick();
      chk("t4_idle", busy, 0);
      // reset during WAIT cycle 3
      req = 4'b0001; set_op(0, 5, 5);
      wait_sig("t5_wait_grant", 1'b0, n);
      chk("t5_grant", grant, 4'b0001);
      req = '0;
      repeat (3) tick();
      chk("t5_busy_mid", busy, 1);
      pulse_rst();
      chk("t5_busy", busy, 0);
      chk("t5_rsp_valid", rsp_valid, 0);
      chk("t5_error", rsp_error, 0);
      chk("t5_cycles", rsp_cycles, 0);
      chk("t5_product", rsp_product, 0);
      chk("t5_mplier", mult_multiplier, 0);
      repeat (4) begin
         tick();
         chk("t5_no_stale_rsp", rsp_valid, 0);
      end
      lat = 4; req = 4'b0010; set_op(1, 7, 9);
      tick();
      chk("t5_grant_after", grant, 4'b0010);
      req = '0;
      wait_sig("t5_wait_rsp", 1'b1, n);
      chk("t5_latency", n, 5);
      chk("t5_product_after", rsp_product, 16'h003F);
      chk("t5_cycles_after", rsp_cycles, 4);
      // done coinciding with the timeout cycle
      lat = 64; req = 4'b0100; set_op(2, 200, 3);
      wait_sig("t6_wait_grant", 1'b0, n);
      chk("t6_grant", grant, 4'b0100);
      req = '0;
      wait_sig("t6_wait_rsp", 1'b1, n);
      chk("t6_latency", n, 65);
      chk("t6_error", rsp_error, 0);
      chk("t6_cycles", rsp_cycles, 64);
      chk("t6_product", rsp_product, 16'h0258);
      tick();
      chk("t6_idle", busy, 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
